// File: rtl/oam_dma.sv
`default_nettype none
// oam_dma: copies NUM_OBJ 32-bit sprite entries from CPU data RAM into PPU OAM,
// optionally gated to vertical blank, with a 2-stage read-to-write pipeline.
module oam_dma #(
  parameter int MEM_AW      = 16,
  parameter int NUM_OBJ     = 64,
  parameter int WAIT_VBLANK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic              rendering,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              oam_write,
  output logic [5:0]        oam_addr,
  output logic [31:0]       oam_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(NUM_OBJ) + 1;
  localparam logic [CW-1:0] LAST_RD = CW'(NUM_OBJ - 1);
  localparam logic [5:0]    LAST_WR = 6'(NUM_OBJ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [CW-1:0]     rc_q, rc_d;
  logic [5:0]        wc_q, wc_d;
  logic              rd_en_q, rd_en_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rvalid_q, rvalid_d;
  logic              wr_q, wr_d;
  logic [5:0]        oaddr_q, oaddr_d;
  logic [31:0]       odata_q, odata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic go;
  logic issue;
  logic last_wr;

  assign go      = (WAIT_VBLANK == 0) || !rendering;
  assign issue   = ((state_q == S_ARM) || (state_q == S_XFER)) && go && !abort;
  assign last_wr = wr_q && (oaddr_q == LAST_WR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      rc_q     <= '0;
      wc_q     <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      wr_q     <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rc_q     <= rc_d;
      wc_q     <= wc_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      wr_q     <= wr_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ARM issues read 0 on the same edge it leaves, so reads begin two cycles after start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM, S_XFER: begin
        if (abort)      state_d = S_IDLE;
        else if (issue) state_d = (rc_q == LAST_RD) ? S_DRAIN : S_XFER;
      end
      S_DRAIN: begin
        if (abort || last_wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d   = base_q;
    rc_d     = rc_q;
    wc_d     = wc_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    rvalid_d = 1'b0;
    wr_d     = 1'b0;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;

    if ((state_q == S_IDLE) && start) begin
      base_d = base_addr;
      rc_d   = '0;
      wc_d   = '0;
    end

    if (issue) begin
      rd_en_d = 1'b1;
      addr_d  = base_q + MEM_AW'(rc_q);
      rc_d    = rc_q + CW'(1);
    end

    // Abort flushes the pipeline so in-flight reads never reach OAM.
    if ((state_q != S_IDLE) && !abort) begin
      rvalid_d = rd_en_q;
      if (rvalid_q) begin
        wr_d    = 1'b1;
        oaddr_d = wc_q;
        odata_d = mem_rdata;
        wc_d    = wc_q + 6'd1;
      end
      done_d = (state_q == S_DRAIN) && last_wr;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign oam_write = wr_q;
  assign oam_addr  = oaddr_q;
  assign oam_data  = odata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// tb_oam_dma: directed scenario tests for oam_dma against a synchronous RAM model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rendering = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        oam_write;
  logic [5:0]  oam_addr;
  logic [31:0] oam_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] ram [0:65535];

  oam_dma #(.MEM_AW(16), .NUM_OBJ(64), .WAIT_VBLANK(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .rendering(rendering),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .oam_write(oam_write), .oam_addr(oam_addr), .oam_data(oam_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read index expected in cycle c (start in cycle 0); -1 when no read.
  function automatic int sched(input int c, input int first, input int p_at, input int p_len);
    int idx;
    if (c < first) return -1;
    if (p_len > 0 && c > p_at && c <= p_at + p_len) return -1;
    idx = c - first;
    if (p_len > 0 && c > p_at + p_len) idx = idx - p_len;
    if (idx > 63) return -1;
    return idx;
  endfunction

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({mem_rd_en, oam_write, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {mem_rd_en, oam_write, busy, done});
    end
    checks++;
    if (mem_addr !== 16'h0 || oam_addr !== 6'h0 || oam_data !== 32'h0) begin
      errors++; $display("FAIL reset_buses got addr=%h oaddr=%h odata=%h expected 0", mem_addr, oam_addr, oam_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int ri, wi;
    for (int i = 0; i < 64; i++) ram[16'h0100 + i] = 32'hA500_0000 | i;
    step(); start = 1'b1; base_addr = 16'h0100;
    for (int c = 1; c <= 70; c++) begin
      step(); start = 1'b0;
      ri = sched(c, 2, 0, 0); wi = sched(c - 2, 2, 0, 0);
      checks++;
      if (mem_rd_en !== (ri >= 0)) begin errors++; $display("FAIL basic_rd_en c=%0d got %b expected %b", c, mem_rd_en, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (mem_addr !== 16'(32'h0100 + ri)) begin errors++; $display("FAIL basic_addr c=%0d got %h expected %h", c, mem_addr, 16'(32'h0100 + ri)); end
      end
      checks++;
      if (oam_write !== (wi >= 0)) begin errors++; $display("FAIL basic_wr c=%0d got %b expected %b", c, oam_write, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (oam_addr !== 6'(wi) || oam_data !== (32'hA500_0000 | wi)) begin
          errors++; $display("FAIL basic_entry c=%0d got %0d/%h expected %0d/%h", c, oam_addr, oam_data, wi, 32'hA500_0000 | wi);
        end
      end
      checks++;
      if (done !== (c == 68) || busy !== (c >= 1 && c <= 67)) begin
        errors++; $display("FAIL basic_done_busy c=%0d got %b/%b expected %b/%b", c, done, busy, c == 68, c >= 1 && c <= 67);
      end
    end
    checks++;
    if (oam_addr !== 6'd63 || oam_data !== 32'hA500_003F) begin
      errors++; $display("FAIL basic_hold got %0d/%h expected 63/a500003f", oam_addr, oam_data);
    end
  endtask

  task automatic test_wrap();
    int ri, wi;
    for (int i = 0; i < 64; i++) ram[(32'hFFE0 + i) & 32'hFFFF] = 32'h3C00_0000 | (i << 8) | i;
    step(); start = 1'b1; base_addr = 16'hFFE0;
    for (int c = 1; c <= 70; c++) begin
      step(); start = 1'b0;
      ri = sched(c, 2, 0, 0); wi = sched(c - 2, 2, 0, 0);
      checks++;
      if (mem_rd_en !== (ri >= 0)) begin errors++; $display("FAIL wrap_rd_en c=%0d got %b expected %b", c, mem_rd_en, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (mem_addr !== 16'(32'hFFE0 + ri)) begin errors++; $display("FAIL wrap_addr c=%0d got %h expected %h", c, mem_addr, 16'(32'hFFE0 + ri)); end
      end
      checks++;
      if (oam_write !== (wi >= 0)) begin errors++; $display("FAIL wrap_wr c=%0d got %b expected %b", c, oam_write, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (oam_addr !== 6'(wi) || oam_data !== (32'h3C00_0000 | (wi << 8) | wi)) begin
          errors++; $display("FAIL wrap_entry c=%0d got %0d/%h expected %0d/%h", c, oam_addr, oam_data, wi, 32'h3C00_0000 | (wi << 8) | wi);
        end
      end
      checks++;
      if (done !== (c == 68)) begin errors++; $display("FAIL wrap_done c=%0d got %b expected %b", c, done, c == 68); end
    end
  endtask

  task automatic test_vblank();
    int ri, wi;
    rendering = 1'b1;
    step(); start = 1'b1; base_addr = 16'h0100;
    for (int c = 1; c <= 80; c++) begin
      step(); start = 1'b0;
      if (c == 10) rendering = 1'b0;
      ri = sched(c, 11, 0, 0); wi = sched(c - 2, 11, 0, 0);
      checks++;
      if (mem_rd_en !== (ri >= 0)) begin errors++; $display("FAIL vblank_rd_en c=%0d got %b expected %b", c, mem_rd_en, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (mem_addr !== 16'(32'h0100 + ri)) begin errors++; $display("FAIL vblank_addr c=%0d got %h expected %h", c, mem_addr, 16'(32'h0100 + ri)); end
      end
      checks++;
      if (oam_write !== (wi >= 0)) begin errors++; $display("FAIL vblank_wr c=%0d got %b expected %b", c, oam_write, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (oam_addr !== 6'(wi) || oam_data !== (32'hA500_0000 | wi)) begin
          errors++; $display("FAIL vblank_entry c=%0d got %0d/%h expected %0d/%h", c, oam_addr, oam_data, wi, 32'hA500_0000 | wi);
        end
      end
      checks++;
      if (done !== (c == 77) || busy !== (c >= 1 && c <= 76)) begin
        errors++; $display("FAIL vblank_done_busy c=%0d got %b/%b expected %b/%b", c, done, busy, c == 77, c >= 1 && c <= 76);
      end
    end
  endtask

  task automatic test_pause();
    int ri, wi;
    step(); start = 1'b1; base_addr = 16'h0100;
    for (int c = 1; c <= 82; c++) begin
      step(); start = 1'b0;
      rendering = (c >= 20 && c <= 29);
      ri = sched(c, 2, 20, 10); wi = sched(c - 2, 2, 20, 10);
      checks++;
      if (mem_rd_en !== (ri >= 0)) begin errors++; $display("FAIL pause_rd_en c=%0d got %b expected %b", c, mem_rd_en, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (mem_addr !== 16'(32'h0100 + ri)) begin errors++; $display("FAIL pause_addr c=%0d got %h expected %h", c, mem_addr, 16'(32'h0100 + ri)); end
      end
      checks++;
      if (oam_write !== (wi >= 0)) begin errors++; $display("FAIL pause_wr c=%0d got %b expected %b", c, oam_write, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (oam_addr !== 6'(wi) || oam_data !== (32'hA500_0000 | wi)) begin
          errors++; $display("FAIL pause_entry c=%0d got %0d/%h expected %0d/%h", c, oam_addr, oam_data, wi, 32'hA500_0000 | wi);
        end
      end
      checks++;
      if (done !== (c == 78) || busy !== (c >= 1 && c <= 77)) begin
        errors++; $display("FAIL pause_done_busy c=%0d got %b/%b expected %b/%b", c, done, busy, c == 78, c >= 1 && c <= 77);
      end
    end
    rendering = 1'b0;
  endtask

  task automatic test_abort();
    int ri, wi, r;
    step(); start = 1'b1; base_addr = 16'h0100;
    for (int c = 1; c <= 110; c++) begin
      step();
      start = (c == 40);
      abort = (c == 30 || c == 40);
      r = (c > 40) ? c - 40 : c;
      if (c > 30 && c <= 40) begin
        ri = -1; wi = -1;
      end else begin
        ri = sched(r, 2, 0, 0); wi = sched(r - 2, 2, 0, 0);
      end
      checks++;
      if (mem_rd_en !== (ri >= 0)) begin errors++; $display("FAIL abort_rd_en c=%0d got %b expected %b", c, mem_rd_en, ri >= 0); end
      checks++;
      if (oam_write !== (wi >= 0)) begin errors++; $display("FAIL abort_wr c=%0d got %b expected %b", c, oam_write, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (oam_addr !== 6'(wi) || oam_data !== (32'hA500_0000 | wi)) begin
          errors++; $display("FAIL abort_entry c=%0d got %0d/%h expected %0d/%h", c, oam_addr, oam_data, wi, 32'hA500_0000 | wi);
        end
      end
      checks++;
      if (done !== (c == 108) || busy !== ((c >= 1 && c <= 30) || (c >= 41 && c <= 107))) begin
        errors++; $display("FAIL abort_done_busy c=%0d got %b/%b expected %b/%b", c, done, busy, c == 108,
                           (c >= 1 && c <= 30) || (c >= 41 && c <= 107));
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_ignored_start_and_reset();
    int ri, wi;
    step(); start = 1'b1; base_addr = 16'h0100;
    for (int c = 1; c <= 25; c++) begin
      step();
      start = (c == 15);
      base_addr = (c == 15) ? 16'h2000 : 16'h0100;
      ri = sched(c, 2, 0, 0); wi = sched(c - 2, 2, 0, 0);
      checks++;
      if (mem_rd_en !== (ri >= 0) || (ri >= 0 && mem_addr !== 16'(32'h0100 + ri))) begin
        errors++; $display("FAIL ign_read c=%0d got %b/%h expected %b/%h", c, mem_rd_en, mem_addr, ri >= 0, 16'(32'h0100 + ri));
      end
      checks++;
      if (oam_write !== (wi >= 0) || (wi >= 0 && oam_addr !== 6'(wi))) begin
        errors++; $display("FAIL ign_write c=%0d got %b/%0d expected %b/%0d", c, oam_write, oam_addr, wi >= 0, wi);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, oam_write, busy, done} !== 4'b0000 || mem_addr !== 16'h0 || oam_addr !== 6'h0 || oam_data !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs got %b %h %h %h expected all 0",
                         {mem_rd_en, oam_write, busy, done}, mem_addr, oam_addr, oam_data);
    end
    repeat (3) step();
    reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      checks++;
      if ({mem_rd_en, oam_write, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL postreset_quiet step=%0d got %b expected 0000", c, {mem_rd_en, oam_write, busy, done});
      end
    end
    start = 1'b1; base_addr = 16'h0100;
    step(); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b expected 1", busy); end
    step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0100) begin
      errors++; $display("FAIL restart_read got %b/%h expected 1/0100", mem_rd_en, mem_addr);
    end
    for (int c = 3; c <= 68; c++) begin
      step();
      checks++;
      if (done !== (c == 68)) begin errors++; $display("FAIL restart_done c=%0d got %b expected %b", c, done, c == 68); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_vblank();
    test_pause();
    test_abort();
    test_ignored_start_and_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
